// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM encodings, frame layout and well-known frames.
package ps2_pkg;

   localparam int unsigned FRAME_BITS = 11;
   localparam int unsigned DATA_BITS  = 8;

   localparam int unsigned START_IDX  = 0;
   localparam int unsigned DATA_LSB   = 1;
   localparam int unsigned PARITY_IDX = 9;
   localparam int unsigned STOP_IDX   = 10;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RECV = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Device acknowledge (0xFA) and host "enable data reporting" (0xF4) frames
   localparam logic [FRAME_BITS-1:0] ACK_FRAME          = 11'b11111110100;
   localparam logic [FRAME_BITS-1:0] EN_REPORTING_FRAME = 11'b10111101000;

   // Frame is bad on a high start bit, a low stop bit or even parity over data+parity
   function automatic logic frame_err(input logic [FRAME_BITS-1:0] f);
      return f[START_IDX] | ~f[STOP_IDX] | ~(^f[PARITY_IDX:DATA_LSB]);
   endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Pin synchroniser with an optional consecutive-sample debouncer (FILTER_LEN=0 disables it).
module ps2_sync_filter #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic pin_i,
   output logic pin_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Metastability chain; resets to the idle (high) bus level
   always_ff @(posedge clk) begin
      if (reset) sync_q <= '1;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
   end

   if (FILTER_LEN > 0) begin : g_filt
      localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
      logic [CNT_W-1:0] cnt_q;
      logic             filt_q;

      // Output flips only after FILTER_LEN consecutive samples disagree with it
      always_ff @(posedge clk) begin
         if (reset) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
         end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
            cnt_q  <= '0;
         end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
            filt_q <= sync_q[SYNC_STAGES-1];
            cnt_q  <= '0;
         end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
         end
      end

      assign pin_o = filt_q;
   end else begin : g_nofilt
      assign pin_o = sync_q[SYNC_STAGES-1];
   end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver.
// Optional macro PS2_CLK_FILTER_EN: debounce the synchronised ps2_clk before edge detection.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 5000,
   parameter int unsigned FILTER_LEN     = 8
) (
   input  logic                  clk_25MHz,
   input  logic                  reset,
   input  logic                  ps2_clk,
   input  logic                  ps2_data,
   input  logic                  tx_active,
   output logic [FRAME_BITS-1:0] rx_data,
   output logic                  data_available,
   output logic                  err,
   output logic                  busy,
   output logic                  frame_timeout
);

   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
`ifdef PS2_CLK_FILTER_EN
   localparam int unsigned CLK_FILT_LEN = FILTER_LEN;
`else
   localparam int unsigned CLK_FILT_LEN = 0;
`endif

   if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2 || FILTER_LEN < 1) begin : g_bad_params
      $error("ps2_rx: illegal parameter value");
   end

   logic clk_s, data_s, clk_prev_q, fall_c, wd_expired_c;

   logic [1:0]            state_q, state_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [WD_W-1:0]       wd_q, wd_d;
   logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
   logic                  err_q, err_d, da_q, da_d, busy_q, busy_d, ft_q, ft_d;

   ps2_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(CLK_FILT_LEN)) u_clk_sync (
      .clk(clk_25MHz), .reset(reset), .pin_i(ps2_clk), .pin_o(clk_s)
   );

   ps2_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(0)) u_data_sync (
      .clk(clk_25MHz), .reset(reset), .pin_i(ps2_data), .pin_o(data_s)
   );

   assign fall_c       = clk_prev_q & ~clk_s;
   assign wd_expired_c = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

   // Next-state, shift register, watchdog and output computation
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      wd_d      = wd_q;
      rx_data_d = rx_data_q;
      err_d     = err_q;
      da_d      = 1'b0;
      ft_d      = 1'b0;

      if (tx_active) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         wd_d      = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (fall_c) begin
                  shift_d   = {data_s, shift_q[FRAME_BITS-1:1]};
                  bit_cnt_d = 4'd1;
                  wd_d      = '0;
                  state_d   = RECV;
               end
            end
            RECV: begin
               if (wd_expired_c) begin
                  ft_d      = 1'b1;
                  bit_cnt_d = '0;
                  wd_d      = '0;
                  state_d   = IDLE;
               end else if (fall_c) begin
                  shift_d   = {data_s, shift_q[FRAME_BITS-1:1]};
                  bit_cnt_d = (bit_cnt_q >= 4'(FRAME_BITS)) ? bit_cnt_q : bit_cnt_q + 4'd1;
                  wd_d      = '0;
                  if (bit_cnt_d == 4'(FRAME_BITS)) state_d = DONE;
               end else begin
                  wd_d = wd_q + WD_W'(1);
               end
            end
            DONE: begin
               da_d      = 1'b1;
               rx_data_d = shift_q;
               err_d     = frame_err(shift_q);
               bit_cnt_d = '0;
               state_d   = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      busy_d = (state_d == RECV);
   end

   // State and output registers
   always_ff @(posedge clk_25MHz) begin
      if (reset) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '1;
         wd_q       <= '0;
         clk_prev_q <= 1'b1;
         rx_data_q  <= '1;
         err_q      <= 1'b0;
         da_q       <= 1'b0;
         busy_q     <= 1'b0;
         ft_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         wd_q       <= wd_d;
         clk_prev_q <= clk_s;
         rx_data_q  <= rx_data_d;
         err_q      <= err_d;
         da_q       <= da_d;
         busy_q     <= busy_d;
         ft_q       <= ft_d;
      end
   end

   assign rx_data        = rx_data_q;
   assign data_available = da_q;
   assign err            = err_q;
   assign busy           = busy_q;
   assign frame_timeout  = ft_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: driver queues expected frames, monitor checks each strobe.
module tb_ps2_rx;

   localparam int unsigned HALF = 50;   // PS/2 half period in system clocks
   localparam int unsigned TO   = 5000;
   localparam int unsigned FL   = 8;
`ifdef PS2_CLK_FILTER_EN
   localparam int LAT = 4 + int'(FL);
`else
   localparam int LAT = 4;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic        tx_active = 1'b0;
   logic [10:0] rx_data;
   logic        data_available, err, busy, frame_timeout;

   typedef struct packed {
      logic [10:0] rx;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   total = 0, bad = 0;
   int   cyc = 0, last_fall_cyc = 0;
   int   ft_count = 0, da_count = 0, n_push = 0;

   ps2_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
      .clk_25MHz(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .tx_active(tx_active), .rx_data(rx_data), .data_available(data_available),
      .err(err), .busy(busy), .frame_timeout(frame_timeout)
   );

   always #20 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [10:0] mkframe(input logic [7:0] d, input logic par);
      return {1'b1, par, d, 1'b0};
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [10:0] rx, input logic e);
      exp_t x;
      x.rx  = rx;
      x.err = e;
      sb.push_back(x);
      n_push++;
   endtask

   // chk: 0 = no busy check, 1 = busy expected high except after a full frame's 11th bit, 2 = busy expected low
   task automatic send_bits(input logic [10:0] f, input int first, input int last, input int chk);
      for (int i = first; i <= last; i++) begin
         ps2_data = f[i];
         cycles(HALF);
         ps2_clk = 1'b0;
         if (i == 10 && first == 0) last_fall_cyc = cyc;
         cycles(HALF);
         if (chk == 1) check($sformatf("busy_bit%0d", i), 32'(busy), 32'(!(i == 10 && first == 0)));
         if (chk == 2) check($sformatf("busy_low_bit%0d", i), 32'(busy), 32'd0);
         ps2_clk = 1'b1;
      end
      cycles(HALF);
   endtask

   // Monitor: count timeout pulses and match each strobe against the scoreboard
   always @(negedge clk) begin
      if (!reset) begin
         if (frame_timeout) ft_count++;
         if (data_available) begin
            exp_t e;
            da_count++;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_strobe: got rx_data=%b with no frame pending", rx_data);
            end else begin
               e = sb.pop_front();
               check("rx_data", 32'(rx_data), 32'(e.rx));
               check("err", 32'(err), 32'(e.err));
               check("latency", 32'(cyc - last_fall_cyc), 32'(LAT));
            end
         end
      end
   end

   initial begin
      logic [10:0] fr;
      cycles(5);
      check("rst_rx_data", 32'(rx_data), 32'h7FF);
      check("rst_err", 32'(err), 32'd0);
      check("rst_da", 32'(data_available), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ft", 32'(frame_timeout), 32'd0);
      reset = 1'b0;
      cycles(20);

`ifdef PS2_CLK_FILTER_EN
      // Short low glitches on ps2_clk while idle must not start a frame
      for (int g = 0; g < 3; g++) begin
         ps2_clk = 1'b0;
         cycles(2);
         ps2_clk = 1'b1;
         cycles(30);
         check($sformatf("glitch_busy%0d", g), 32'(busy), 32'd0);
      end
      cycles(TO + 200);
      check("glitch_no_timeout", 32'(ft_count), 32'd0);
      check("glitch_no_strobe", 32'(da_count), 32'd0);
`endif

      // 0xFA, odd parity bit 1 -> acknowledge frame, no error
      push(11'b11111110100, 1'b0);
      send_bits(mkframe(8'hFA, 1'b1), 0, 10, 1);
      cycles(200);

      // 0x00 with parity forced low -> parity error
      push(11'b10000000000, 1'b1);
      send_bits(mkframe(8'h00, 1'b0), 0, 10, 1);
      cycles(200);
      check("err_held", 32'(err), 32'd1);

      // Partial frame then silence -> single timeout pulse, no strobe
      send_bits(mkframe(8'hAA, 1'b1), 0, 4, 1);
      cycles(TO + 500);
      check("timeout_count", 32'(ft_count), 32'd1);
      check("timeout_busy", 32'(busy), 32'd0);
      check("timeout_no_strobe", 32'(da_count), 32'd2);

      // 0xAA has four ones, so correct odd parity is 1
      push(11'b11101010100, 1'b0);
      send_bits(mkframe(8'hAA, 1'b1), 0, 10, 1);
      cycles(200);

      // tx_active aborts a partial frame; falls while it is high are ignored
      send_bits(mkframe(8'h33, 1'b1), 0, 3, 1);
      tx_active = 1'b1;
      cycles(2);
      check("tx_abort_busy", 32'(busy), 32'd0);
      send_bits(mkframe(8'h33, 1'b1), 4, 5, 2);
      tx_active = 1'b0;
      cycles(100);
      push(11'b10111101000, 1'b0);
      send_bits(mkframe(8'hF4, 1'b0), 0, 10, 1);
      cycles(200);
      check("tx_rx_data_held", 32'(rx_data), 32'h5E8);

      // One-cycle reset mid-frame
      fr = mkframe(8'h55, 1'b1);
      send_bits(fr, 0, 2, 1);
      reset = 1'b1;
      cycles(1);
      check("mid_rst_rx_data", 32'(rx_data), 32'h7FF);
      check("mid_rst_err", 32'(err), 32'd0);
      check("mid_rst_da", 32'(data_available), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ft", 32'(frame_timeout), 32'd0);
      reset = 1'b0;
      // Remaining 8 bits look like a new, incomplete frame and must time out
      send_bits(fr, 3, 10, 1);
      cycles(TO + 500);
      check("post_rst_timeout", 32'(ft_count), 32'd2);
      check("post_rst_rx_data", 32'(rx_data), 32'h7FF);

      cycles(100);
      check("sb_empty", 32'(sb.size()), 32'd0);
      check("strobe_count", 32'(da_count), 32'(n_push));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
